// File: rtl/count_match_pulse_pkg.sv
// Shared types and constants for the count-match pulse generator.
package count_match_pulse_pkg;

  // Control FSM states; encodings are fixed so downstream debug taps can decode them.
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArmed   = 2'd1,
    StPulse   = 2'd2,
    StHoldoff = 2'd3
  } state_e;

  // Width of the optional missed-hit counter.
  localparam int unsigned MissedWidth = 8;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/count_match_cmp.sv
// Registered stage-1 comparator: flags a qualified count equal to the match value.
module count_match_cmp
  import count_match_pulse_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] count,
  input  logic [DATA_WIDTH-1:0] match_val,
  output logic                  hit_q
);

  // Full-width equality, qualified by en; a hit seen during reset is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q <= 1'b0;
    end else begin
      hit_q <= en & (count == match_val);
    end
  end

endmodule

// File: rtl/count_match_pulse.sv
// Count-match pulse generator: arms, waits for a registered count hit, emits a
// fixed-length pulse followed by an optional hold-off, in periodic or one-shot mode.
// Optional feature: define COUNT_MATCH_PULSE_MISSED_EN to add the saturating
// 'missed' counter of hits that arrive while busy.
module count_match_pulse
  import count_match_pulse_pkg::*;
#(
  parameter string       ARCHITECTURE = "BEHAVIORAL",
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned PULSE_LEN    = 4,
  parameter int unsigned HOLDOFF      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] count,
  input  logic [DATA_WIDTH-1:0] match_val,
  input  logic                  arm,
  input  logic                  one_shot,
  input  logic                  disarm,
  output logic                  pulse,
  output logic                  armed,
  output logic                  busy,
  output logic                  done
`ifdef COUNT_MATCH_PULSE_MISSED_EN
  ,
  output logic [MissedWidth-1:0] missed
`endif
);

  // Shared length counter covers both the pulse and the hold-off phases.
  localparam int unsigned LenW = $clog2(max_u(PULSE_LEN, HOLDOFF) + 1);
  localparam logic [LenW-1:0] PulseLoad = LenW'(PULSE_LEN - 1);
  localparam logic [LenW-1:0] HoldLoad  = LenW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  if (ARCHITECTURE != "BEHAVIORAL") begin : g_arch_check
    $error("count_match_pulse: only BEHAVIORAL architecture is implemented");
  end
  if (PULSE_LEN < 1) begin : g_len_check
    $error("count_match_pulse: PULSE_LEN must be at least 1");
  end

  logic            hit_q;
  state_e          state_q, state_d;
  logic [LenW-1:0] len_q, len_d;
  logic            mode_q, mode_d;
  logic            done_q, done_d;
  logic            cycle_end;

  count_match_cmp #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_cmp (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .count    (count),
    .match_val(match_val),
    .hit_q    (hit_q)
  );

  // Next-state, length counter and done strobe; disarm overrides everything.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    mode_d    = mode_q;
    done_d    = 1'b0;
    cycle_end = 1'b0;
    if (disarm) begin
      state_d = StIdle;
      len_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (arm) begin
            state_d = StArmed;
            mode_d  = one_shot;
          end
        end
        StArmed: begin
          if (hit_q) begin
            state_d = StPulse;
            len_d   = PulseLoad;
          end
        end
        StPulse: begin
          if (len_q == '0) begin
            if (HOLDOFF > 0) begin
              state_d = StHoldoff;
              len_d   = HoldLoad;
            end else begin
              cycle_end = 1'b1;
            end
          end else begin
            len_d = len_q - LenW'(1);
          end
        end
        StHoldoff: begin
          if (len_q == '0) begin
            cycle_end = 1'b1;
          end else begin
            len_d = len_q - LenW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
      // Periodic mode re-arms; one-shot retires to idle and flags completion.
      if (cycle_end) begin
        state_d = mode_q ? StIdle : StArmed;
        done_d  = mode_q;
      end
    end
  end

  // State, counter, mode and done registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      len_q   <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  assign pulse = (state_q == StPulse);
  assign armed = (state_q == StArmed);
  assign busy  = (state_q == StPulse) || (state_q == StHoldoff);
  assign done  = done_q;

`ifdef COUNT_MATCH_PULSE_MISSED_EN
  logic [MissedWidth-1:0] missed_q;
  logic                   arm_acc;

  assign arm_acc = (state_q == StIdle) && arm && !disarm;

  // Saturating count of hits that land while a pulse/hold-off is in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      missed_q <= '0;
    end else if (arm_acc) begin
      missed_q <= '0;
    end else if (hit_q && busy && (missed_q != '1)) begin
      missed_q <= missed_q + MissedWidth'(1);
    end
  end

  assign missed = missed_q;
`endif

endmodule

// File: tb/tb_count_match_pulse.sv
// Self-checking bench for count_match_pulse: directed vector table, hand-written
// abort sequence, and randomized stimulus against a timestamp-based reference model.
module tb_count_match_pulse;

  localparam int unsigned DW = 8;
  localparam int PL = 4;
  localparam int HO = 2;

  logic          clk = 1'b0;
  logic          rst, en, arm, one_shot, disarm;
  logic [DW-1:0] count, match_val;
  logic          pulse, armed, busy, done;
`ifdef COUNT_MATCH_PULSE_MISSED_EN
  logic [7:0]    missed;
`endif

  always #5 clk = ~clk;

  count_match_pulse #(
    .ARCHITECTURE("BEHAVIORAL"),
    .DATA_WIDTH  (DW),
    .PULSE_LEN   (PL),
    .HOLDOFF     (HO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .count    (count),
    .match_val(match_val),
    .arm      (arm),
    .one_shot (one_shot),
    .disarm   (disarm),
    .pulse    (pulse),
    .armed    (armed),
    .busy     (busy),
    .done     (done)
`ifdef COUNT_MATCH_PULSE_MISSED_EN
    ,
    .missed   (missed)
`endif
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] cnt;
    logic [7:0] mv;
    logic       arm;
    logic       os;
    logic       dis;
    logic [3:0] exp;  // {pulse, armed, busy, done}
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model: 'active' means armed or in a cycle; a cycle is described by the
  // index of the clock cycle in which its pulse begins.
  bit m_active = 1'b0;
  bit m_mode   = 1'b0;
  bit m_hitp   = 1'b0;
  bit m_done   = 1'b0;
  int m_start  = -1;
  int m_cyc    = 0;
  int m_missed = 0;

  always @(posedge clk) begin : model
    int c;
    bit busy_now;
    c        = m_cyc + 1;
    busy_now = m_active && (m_start >= 0);
    m_cyc   <= c;
    if (rst) begin
      m_active <= 1'b0;
      m_start  <= -1;
      m_hitp   <= 1'b0;
      m_done   <= 1'b0;
      m_missed <= 0;
    end else begin
      m_hitp <= en && (count == match_val);
      m_done <= 1'b0;
      if (busy_now && m_hitp && m_missed < 255) m_missed <= m_missed + 1;
      if (disarm) begin
        m_active <= 1'b0;
        m_start  <= -1;
      end else if (!m_active) begin
        if (arm) begin
          m_active <= 1'b1;
          m_mode   <= one_shot;
          m_start  <= -1;
          m_missed <= 0;
        end
      end else if (m_start < 0) begin
        if (m_hitp) m_start <= c;
      end else if (c == m_start + PL + HO) begin
        m_start <= -1;
        if (m_mode) begin
          m_active <= 1'b0;
          m_done   <= 1'b1;
        end
      end
    end
  end

  function automatic logic [3:0] model_out();
    logic p, a, b;
    b = m_active && (m_start >= 0);
    a = m_active && (m_start < 0);
    p = b && (m_cyc < m_start + PL);
    return {p, a, b, m_done};
  endfunction

  function automatic vec_t mk(input logic r, input logic e, input logic [7:0] c,
                              input logic a, input logic o, input logic d,
                              input logic [3:0] x);
    vec_t v;
    v.rst = r; v.en = e; v.cnt = c; v.mv = 8'd25;
    v.arm = a; v.os = o; v.dis = d; v.exp = x;
    return v;
  endfunction

  // Inputs change on the falling edge; outputs are sampled on the next falling edge.
  task automatic drive(input logic r, input logic e, input logic [7:0] c,
                       input logic [7:0] m, input logic a, input logic o, input logic d);
    rst = r; en = e; count = c; match_val = m; arm = a; one_shot = o; disarm = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input int idx, input logic [3:0] exp);
    logic [3:0] act;
    act = {pulse, armed, busy, done};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s #%0d: pulse/armed/busy/done got %b want %b", name, idx, act, exp);
    end
  endtask

`ifdef COUNT_MATCH_PULSE_MISSED_EN
  task automatic check_missed(input string name, input int idx, input int exp);
    n_vec++;
    if (int'(missed) != exp) begin
      n_bad++;
      $display("FAIL %s #%0d: missed got %0d want %0d", name, idx, missed, exp);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; en = 1'b0; count = '0; match_val = 8'd25;
    arm = 1'b0; one_shot = 1'b0; disarm = 1'b0;
    @(negedge clk);

    // Directed table: row k drives cycle k, expects outputs of cycle k+1.
    tbl.push_back(mk(1, 0, 8'd0,  0, 0, 0, 4'b0000));
    // periodic: arm, hit at count 25 (row 6), pulse 4, hold-off 2, re-arm
    tbl.push_back(mk(0, 1, 8'd20, 1, 0, 0, 4'b0100));
    for (int c = 21; c <= 25; c++) tbl.push_back(mk(0, 1, 8'(c), 0, 0, 0, 4'b0100));
    for (int c = 26; c <= 29; c++) tbl.push_back(mk(0, 1, 8'(c), 0, 0, 0, 4'b1010));
    tbl.push_back(mk(0, 1, 8'd30, 0, 0, 0, 4'b0010));
    tbl.push_back(mk(0, 1, 8'd31, 0, 0, 0, 4'b0010));
    tbl.push_back(mk(0, 1, 8'd32, 0, 0, 0, 4'b0100));
    tbl.push_back(mk(0, 1, 8'd25, 0, 0, 0, 4'b0100));
    tbl.push_back(mk(0, 1, 8'd26, 0, 0, 0, 4'b1010));
    tbl.push_back(mk(0, 1, 8'd27, 0, 0, 1, 4'b0000));
    // one-shot: single pulse, done on first idle cycle, later match ignored
    tbl.push_back(mk(0, 1, 8'd20, 1, 1, 0, 4'b0100));
    for (int c = 21; c <= 25; c++) tbl.push_back(mk(0, 1, 8'(c), 0, 0, 0, 4'b0100));
    for (int c = 26; c <= 29; c++) tbl.push_back(mk(0, 1, 8'(c), 0, 0, 0, 4'b1010));
    tbl.push_back(mk(0, 1, 8'd30, 0, 0, 0, 4'b0010));
    tbl.push_back(mk(0, 1, 8'd31, 0, 0, 0, 4'b0010));
    tbl.push_back(mk(0, 1, 8'd32, 0, 0, 0, 4'b0001));
    for (int c = 25; c <= 27; c++) tbl.push_back(mk(0, 1, 8'(c), 0, 0, 0, 4'b0000));
    // arm and disarm together: disarm wins
    tbl.push_back(mk(0, 1, 8'd19, 1, 0, 1, 4'b0000));
    tbl.push_back(mk(0, 1, 8'd20, 0, 0, 0, 4'b0000));
    // en low during the match: stays armed
    tbl.push_back(mk(0, 1, 8'd20, 1, 0, 0, 4'b0100));
    tbl.push_back(mk(0, 0, 8'd25, 0, 0, 0, 4'b0100));
    tbl.push_back(mk(0, 1, 8'd26, 0, 0, 0, 4'b0100));
    tbl.push_back(mk(0, 1, 8'd27, 0, 0, 0, 4'b0100));
    // reset the cycle after a hit: pulse never rises
    tbl.push_back(mk(0, 1, 8'd25, 0, 0, 0, 4'b0100));
    tbl.push_back(mk(1, 1, 8'd26, 0, 0, 0, 4'b0000));
    tbl.push_back(mk(0, 1, 8'd27, 0, 0, 0, 4'b0000));
    tbl.push_back(mk(0, 1, 8'd28, 0, 0, 0, 4'b0000));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].cnt, tbl[i].mv, tbl[i].arm, tbl[i].os, tbl[i].dis);
      check("table", i, tbl[i].exp);
    end

    // Disarm in the second pulse cycle (N+3): everything low from N+4, no done.
    drive(1, 0, 8'd0, 8'd25, 0, 0, 0);
    drive(0, 1, 8'd20, 8'd25, 1, 0, 0);
    for (int c = 21; c <= 25; c++) drive(0, 1, 8'(c), 8'd25, 0, 0, 0);
    drive(0, 1, 8'd26, 8'd25, 0, 0, 0);
    check("abort_pulse_n2", 0, 4'b1010);
    drive(0, 1, 8'd27, 8'd25, 0, 0, 0);
    check("abort_pulse_n3", 0, 4'b1010);
    drive(0, 1, 8'd28, 8'd25, 0, 0, 1);
    check("abort_n4", 0, 4'b0000);
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 8'(29 + k), 8'd25, 0, 0, 0);
      check("abort_after", k, 4'b0000);
    end

    // Randomized stimulus against the reference model.
    drive(1, 0, 8'd0, 8'd25, 0, 0, 0);
    for (int i = 0; i < 2000; i++) begin
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 4) != 0),
            8'($urandom_range(20, 27)),
            ($urandom_range(0, 9) == 0) ? 8'($urandom_range(20, 27)) : 8'd25,
            ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 39) == 0));
      check("random", i, model_out());
`ifdef COUNT_MATCH_PULSE_MISSED_EN
      check_missed("random_missed", i, m_missed);
`endif
    end

`ifdef COUNT_MATCH_PULSE_MISSED_EN
    // Count held on the match value: missed climbs every busy cycle and saturates.
    drive(1, 0, 8'd0, 8'd25, 0, 0, 0);
    drive(0, 1, 8'd25, 8'd25, 1, 0, 0);
    for (int i = 0; i < 400; i++) begin
      drive(0, 1, 8'd25, 8'd25, 0, 0, 0);
      check("sat_fsm", i, model_out());
      check_missed("sat_missed", i, m_missed);
    end
    check_missed("sat_final", 0, 255);
    drive(0, 1, 8'd25, 8'd25, 0, 0, 1);
    drive(0, 1, 8'd25, 8'd25, 1, 0, 0);
    check_missed("rearm_clear", 0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
